uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level.
// Both flops reset to the idle-high line value.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver, 16x oversampled, LSB first.
// Define UART_RX_PARITY_EN to add a parity bit and parity_err check.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT       = UART_DBIT,
  parameter int SB_TICK    = UART_SB_TICK,
  parameter int PARITY_ODD = 0
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            sample_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;
  logic            rx_prev_q;
  logic            fall;

  sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Start only on a real edge, so a held-low break waits for recovery.
  assign fall = rx_prev_q & ~rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          s_d     = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (s_q == SW'(7)) begin
            if (!rx_s) begin
              state_d = S_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_tick) begin
          if (s_q == SW'(15)) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = S_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (sample_tick) begin
          if (s_q == SW'(SB_TICK-1)) begin
            state_d = S_IDLE;
            data_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^b_q) ^ par_q ^ (PARITY_ODD != 0);
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0 & (PARITY_ODD != 0);
`endif

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule
